// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the two CDB/PRF writeback lanes.
// Define CDB_ARB_MUL_PRIO_EN to give the multiplier fixed lane-0 priority.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 64,
    parameter int PR_W   = 7,
    parameter int AR_W   = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_req,
    input  logic [NUM_FU*DATA_W-1:0] fu_result,
    input  logic [NUM_FU*AR_W-1:0]   fu_dest_ar_idx,
    input  logic [NUM_FU*PR_W-1:0]   fu_dest_pr_idx,
    input  logic [NUM_FU-1:0]        fu_exception,
    output logic [NUM_FU-1:0]        fu_grant,
    output logic                     cdb_complete0,
    output logic                     cdb_complete1,
    output logic [AR_W-1:0]          cdb_dest_ar_idx0,
    output logic [AR_W-1:0]          cdb_dest_ar_idx1,
    output logic [PR_W-1:0]          cdb_prf_dest_pr_idx0,
    output logic [PR_W-1:0]          cdb_prf_dest_pr_idx1,
    output logic                     cdb_exception0,
    output logic                     cdb_exception1,
    output logic [DATA_W-1:0]        prf_result0,
    output logic [DATA_W-1:0]        prf_result1,
    output logic                     prf_write_enable0,
    output logic                     prf_write_enable1
);

    localparam int PTR_W = (NUM_FU > 2) ? $clog2(NUM_FU) : 1;
`ifdef CDB_ARB_MUL_PRIO_EN
    localparam int RR_N = NUM_FU - 1;
`else
    localparam int RR_N = NUM_FU;
`endif
    localparam logic [PTR_W-1:0] MUL_IDX = PTR_W'(NUM_FU - 1);
    localparam logic [AR_W-1:0]  ZERO_AR = AR_W'(31);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_nxt;
    logic              first_ok;
    logic              second_ok;
    logic [PTR_W-1:0]  first_idx;
    logic [PTR_W-1:0]  second_idx;
    int                first_pos;
    int                second_pos;
    int                pos;
    int                nxt_int;
    logic              lane0_v;
    logic              lane1_v;
    logic              upd;
    logic [PTR_W-1:0]  lane0_idx;
    logic [PTR_W-1:0]  lane1_idx;
    logic [PTR_W-1:0]  last_idx;
    logic [DATA_W-1:0] res0;
    logic [DATA_W-1:0] res1;
    logic [AR_W-1:0]   ar0;
    logic [AR_W-1:0]   ar1;
    logic [PR_W-1:0]   pr0;
    logic [PR_W-1:0]   pr1;
    logic              exc0;
    logic              exc1;

    // Keep the two requesters closest to rr_ptr in scan order.
    always_comb begin
        first_ok   = 1'b0;
        second_ok  = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        first_pos  = RR_N;
        second_pos = RR_N;
        pos        = 0;
        for (int i = 0; i < RR_N; i++) begin
            pos = i - int'(rr_ptr);
            if (pos < 0) pos = pos + RR_N;
            if (fu_req[i]) begin
                if (pos < first_pos) begin
                    second_ok  = first_ok;
                    second_idx = first_idx;
                    second_pos = first_pos;
                    first_ok   = 1'b1;
                    first_idx  = PTR_W'(i);
                    first_pos  = pos;
                end else if (pos < second_pos) begin
                    second_ok  = 1'b1;
                    second_idx = PTR_W'(i);
                    second_pos = pos;
                end
            end
        end
    end

    always_comb begin
        lane0_v   = first_ok;
        lane0_idx = first_idx;
        lane1_v   = second_ok;
        lane1_idx = second_idx;
        upd       = first_ok;
        last_idx  = second_ok ? second_idx : first_idx;
`ifdef CDB_ARB_MUL_PRIO_EN
        if (fu_req[NUM_FU-1]) begin
            lane0_v   = 1'b1;
            lane0_idx = MUL_IDX;
            lane1_v   = first_ok;
            lane1_idx = first_idx;
            last_idx  = first_idx;
        end
`endif
        if (reset || flush) begin
            lane0_v = 1'b0;
            lane1_v = 1'b0;
            upd     = 1'b0;
        end
    end

    always_comb begin
        nxt_int = int'(last_idx) + 1;
        if (nxt_int >= RR_N) nxt_int = 0;
        rr_nxt = PTR_W'(nxt_int);
    end

    always_comb begin
        fu_grant = '0;
        res0 = '0;
        res1 = '0;
        ar0  = '0;
        ar1  = '0;
        pr0  = '0;
        pr1  = '0;
        exc0 = 1'b0;
        exc1 = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_grant[i] = (lane0_v && lane0_idx == PTR_W'(i)) ||
                          (lane1_v && lane1_idx == PTR_W'(i));
            if (lane0_idx == PTR_W'(i)) begin
                res0 = fu_result[i*DATA_W +: DATA_W];
                ar0  = fu_dest_ar_idx[i*AR_W +: AR_W];
                pr0  = fu_dest_pr_idx[i*PR_W +: PR_W];
                exc0 = fu_exception[i];
            end
            if (lane1_idx == PTR_W'(i)) begin
                res1 = fu_result[i*DATA_W +: DATA_W];
                ar1  = fu_dest_ar_idx[i*AR_W +: AR_W];
                pr1  = fu_dest_pr_idx[i*PR_W +: PR_W];
                exc1 = fu_exception[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr               <= '0;
            cdb_complete0        <= 1'b0;
            cdb_complete1        <= 1'b0;
            cdb_dest_ar_idx0     <= '0;
            cdb_dest_ar_idx1     <= '0;
            cdb_prf_dest_pr_idx0 <= '0;
            cdb_prf_dest_pr_idx1 <= '0;
            cdb_exception0       <= 1'b0;
            cdb_exception1       <= 1'b0;
            prf_result0          <= '0;
            prf_result1          <= '0;
        end else begin
            cdb_complete0 <= lane0_v;
            cdb_complete1 <= lane1_v;
            if (upd) rr_ptr <= rr_nxt;
            if (lane0_v) begin
                cdb_dest_ar_idx0     <= ar0;
                cdb_prf_dest_pr_idx0 <= pr0;
                cdb_exception0       <= exc0;
                prf_result0          <= res0;
            end
            if (lane1_v) begin
                cdb_dest_ar_idx1     <= ar1;
                cdb_prf_dest_pr_idx1 <= pr1;
                cdb_exception1       <= exc1;
                prf_result1          <= res1;
            end
        end
    end

    assign prf_write_enable0 = cdb_complete0 & ~cdb_exception0 &
                               (cdb_dest_ar_idx0 != ZERO_AR);
    assign prf_write_enable1 = cdb_complete1 & ~cdb_exception1 &
                               (cdb_dest_ar_idx1 != ZERO_AR);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus random checks of cdb_arbiter
// against a scan-order reference model.
module tb_cdb_arbiter;

    localparam int N = 4;
    localparam int DW = 64;
    localparam int PW = 7;
    localparam int AW = 5;
`ifdef CDB_ARB_MUL_PRIO_EN
    localparam int RRN = N - 1;
`else
    localparam int RRN = N;
`endif

    logic            clock;
    logic            reset;
    logic            flush;
    logic [N-1:0]    fu_req;
    logic [N*DW-1:0] fu_result;
    logic [N*AW-1:0] fu_dest_ar_idx;
    logic [N*PW-1:0] fu_dest_pr_idx;
    logic [N-1:0]    fu_exception;
    logic [N-1:0]    fu_grant;
    logic            cdb_complete0, cdb_complete1;
    logic [AW-1:0]   cdb_dest_ar_idx0, cdb_dest_ar_idx1;
    logic [PW-1:0]   cdb_prf_dest_pr_idx0, cdb_prf_dest_pr_idx1;
    logic            cdb_exception0, cdb_exception1;
    logic [DW-1:0]   prf_result0, prf_result1;
    logic            prf_write_enable0, prf_write_enable1;

    cdb_arbiter dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_req(fu_req), .fu_result(fu_result),
        .fu_dest_ar_idx(fu_dest_ar_idx),
        .fu_dest_pr_idx(fu_dest_pr_idx),
        .fu_exception(fu_exception), .fu_grant(fu_grant),
        .cdb_complete0(cdb_complete0), .cdb_complete1(cdb_complete1),
        .cdb_dest_ar_idx0(cdb_dest_ar_idx0),
        .cdb_dest_ar_idx1(cdb_dest_ar_idx1),
        .cdb_prf_dest_pr_idx0(cdb_prf_dest_pr_idx0),
        .cdb_prf_dest_pr_idx1(cdb_prf_dest_pr_idx1),
        .cdb_exception0(cdb_exception0), .cdb_exception1(cdb_exception1),
        .prf_result0(prf_result0), .prf_result1(prf_result1),
        .prf_write_enable0(prf_write_enable0),
        .prf_write_enable1(prf_write_enable1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] p_res [N];
    logic [AW-1:0] p_ar  [N];
    logic [PW-1:0] p_pr  [N];
    logic          p_exc [N];

    int            m_rr;
    logic          m_c0, m_c1, m_e0, m_e1;
    logic [AW-1:0] m_ar0, m_ar1;
    logic [PW-1:0] m_pr0, m_pr1;
    logic [DW-1:0] m_res0, m_res1;
    logic [N-1:0]  last_g;
    logic [N-1:0]  cur_req;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        p_res[i] = {$urandom, $urandom};
        p_ar[i]  = ($urandom_range(0, 7) == 0) ? AW'(31) : AW'($urandom_range(0, 31));
        p_pr[i]  = PW'($urandom_range(0, 127));
        p_exc[i] = ($urandom_range(0, 7) == 0);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            fu_result[i*DW +: DW]      = p_res[i];
            fu_dest_ar_idx[i*AW +: AW] = p_ar[i];
            fu_dest_pr_idx[i*PW +: PW] = p_pr[i];
            fu_exception[i]            = p_exc[i];
        end
    endtask

    // One clock: drive at negedge, check grant, then check lanes after the edge.
    task automatic cycle(input logic [N-1:0] req, input bit fl, input bit rs,
                         input bit chk_g, input logic [N-1:0] g_want);
        int w[2];
        int n;
        int idx;
        int last;
        bit any;
        logic [N-1:0] g_exp;
        fu_req = req;
        flush  = fl;
        reset  = rs;
        drive();
        #1;
        n = 0;
        any = 0;
        last = 0;
        w[0] = 0;
        w[1] = 0;
        if (!rs && !fl) begin
`ifdef CDB_ARB_MUL_PRIO_EN
            if (req[N-1]) begin
                w[0] = N - 1;
                n = 1;
            end
`endif
            for (int k = 0; k < RRN; k++) begin
                idx = (m_rr + k) % RRN;
                if (n < 2 && req[idx]) begin
                    w[n] = idx;
                    n++;
                    any = 1;
                    last = idx;
                end
            end
        end
        g_exp = '0;
        for (int k = 0; k < n; k++) g_exp[w[k]] = 1'b1;
        last_g = g_exp;
        check("grant", 64'(fu_grant), 64'(g_exp));
        if (chk_g) check("grant_directed", 64'(fu_grant), 64'(g_want));
        @(posedge clock);
        if (rs) begin
            m_rr = 0;
            m_c0 = 0; m_c1 = 0; m_e0 = 0; m_e1 = 0;
            m_ar0 = '0; m_ar1 = '0; m_pr0 = '0; m_pr1 = '0;
            m_res0 = '0; m_res1 = '0;
        end else begin
            m_c0 = (n > 0);
            m_c1 = (n > 1);
            if (n > 0) begin
                m_ar0 = p_ar[w[0]]; m_pr0 = p_pr[w[0]];
                m_e0 = p_exc[w[0]]; m_res0 = p_res[w[0]];
            end
            if (n > 1) begin
                m_ar1 = p_ar[w[1]]; m_pr1 = p_pr[w[1]];
                m_e1 = p_exc[w[1]]; m_res1 = p_res[w[1]];
            end
            if (any) m_rr = (last + 1) % RRN;
        end
        #1;
        check("complete0", 64'(cdb_complete0), 64'(m_c0));
        check("complete1", 64'(cdb_complete1), 64'(m_c1));
        check("ar0", 64'(cdb_dest_ar_idx0), 64'(m_ar0));
        check("ar1", 64'(cdb_dest_ar_idx1), 64'(m_ar1));
        check("pr0", 64'(cdb_prf_dest_pr_idx0), 64'(m_pr0));
        check("pr1", 64'(cdb_prf_dest_pr_idx1), 64'(m_pr1));
        check("exc0", 64'(cdb_exception0), 64'(m_e0));
        check("exc1", 64'(cdb_exception1), 64'(m_e1));
        check("res0", prf_result0, m_res0);
        check("res1", prf_result1, m_res1);
        check("we0", 64'(prf_write_enable0),
              64'(m_c0 && !m_e0 && m_ar0 != AW'(31)));
        check("we1", 64'(prf_write_enable1),
              64'(m_c1 && !m_e1 && m_ar1 != AW'(31)));
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        fu_req = '0;
        m_rr = 0;
        last_g = '0;
        for (int i = 0; i < N; i++) begin
            p_res[i] = DW'(100 + i);
            p_ar[i]  = AW'(i + 1);
            p_pr[i]  = PW'(20 + i);
            p_exc[i] = 1'b0;
        end
        drive();
        @(negedge clock);

        // Reset held with every unit requesting.
        cycle(4'b1111, 0, 1, 1, 4'b0000);
        cycle(4'b1111, 0, 1, 1, 4'b0000);

        // Single request lands on lane 0.
        p_res[0] = 64'd35; p_ar[0] = 5'd3; p_pr[0] = 7'd40;
        cycle(4'b0001, 0, 0, 1, 4'b0001);
        check("single_c0", 64'(cdb_complete0), 64'd1);
        check("single_res0", prf_result0, 64'd35);
        check("single_pr0", 64'(cdb_prf_dest_pr_idx0), 64'd40);
        check("single_we0", 64'(prf_write_enable0), 64'd1);
        check("single_c1", 64'(cdb_complete1), 64'd0);

        // Four continuous requesters from rr_ptr 0.
        cycle(4'b0000, 0, 1, 0, 4'b0000);
`ifdef CDB_ARB_MUL_PRIO_EN
        cycle(4'b1111, 0, 0, 1, 4'b1001);
        cycle(4'b1111, 0, 0, 1, 4'b1010);
        cycle(4'b1111, 0, 0, 1, 4'b1100);
`else
        cycle(4'b1111, 0, 0, 1, 4'b0011);
        cycle(4'b1111, 0, 0, 1, 4'b1100);
        cycle(4'b1111, 0, 0, 1, 4'b0011);
`endif

        // Zero-register destination and exception suppress the write.
        p_ar[2] = 5'd31; p_exc[2] = 1'b0;
        cycle(4'b0100, 0, 0, 1, 4'b0100);
        check("zreg_c0", 64'(cdb_complete0), 64'd1);
        check("zreg_we0", 64'(prf_write_enable0), 64'd0);
        p_ar[1] = 5'd5; p_exc[1] = 1'b1;
        cycle(4'b0010, 0, 0, 1, 4'b0010);
        check("exc_c0", 64'(cdb_complete0), 64'd1);
        check("exc_we0", 64'(prf_write_enable0), 64'd0);

        // Flush squashes grants, then the same requests win.
        cycle(4'b0110, 1, 0, 1, 4'b0000);
        check("flush_c0", 64'(cdb_complete0), 64'd0);
        check("flush_c1", 64'(cdb_complete1), 64'd0);
        cycle(4'b0110, 0, 0, 1, 4'b0110);

        // Multiplier plus two ALUs from rr_ptr 0.
        cycle(4'b1011, 1, 1, 1, 4'b0000);
`ifdef CDB_ARB_MUL_PRIO_EN
        cycle(4'b1011, 0, 0, 1, 4'b1001);
        check("mul_res0", prf_result0, p_res[3]);
        check("mul_res1", prf_result1, p_res[0]);
`else
        cycle(4'b1011, 0, 0, 1, 4'b0011);
        check("rr_res0", prf_result0, p_res[0]);
        check("rr_res1", prf_result1, p_res[1]);
`endif

        // Random traffic: losers hold payload, winners re-roll.
        cur_req = '0;
        for (int i = 0; i < N; i++) new_payload(i);
        for (int t = 0; t < 400; t++) begin
            cycle(cur_req, ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 49) == 0), 0, 4'b0000);
            for (int i = 0; i < N; i++) begin
                if (last_g[i] || !cur_req[i]) begin
                    cur_req[i] = ($urandom_range(0, 9) < 7);
                    new_payload(i);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two CDB/PRF-writeback lanes among NUM_FU execution-unit completion requesters: ALU pipes 0..NUM_FU-2 and the multiplier at index NUM_FU-1.
- Each cycle it picks up to two requesters with a rotating round-robin pointer and returns a same-cycle grant.
- It registers the winners' payloads onto the CDB/PRF lane outputs.
- Losing units hold their result. Grant status is the back-pressure that drives rs_alu_avail in the execution units.

Parameters:
- NUM_FU, 4, number of requesters (2..8); index NUM_FU-1 is the multiplier.
- DATA_W, 64, result width.
- PR_W, 7, physical register index width.
- AR_W, 5, architectural register index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  branch-mispredict squash
- fu_req  in  NUM_FU  completion request per unit
- fu_result  in  NUM_FU*DATA_W  result; unit i at bits [i*DATA_W +: DATA_W]
- fu_dest_ar_idx  in  NUM_FU*AR_W  architectural destination per unit
- fu_dest_pr_idx  in  NUM_FU*PR_W  physical destination per unit
- fu_exception  in  NUM_FU  exception flag per unit
- fu_grant  out  NUM_FU  combinational grant, one-hot-or-two-hot
- cdb_complete0, cdb_complete1  out  1  lane valid
- cdb_dest_ar_idx0, cdb_dest_ar_idx1  out  AR_W  lane architectural destination
- cdb_prf_dest_pr_idx0, cdb_prf_dest_pr_idx1  out  PR_W  lane physical destination
- cdb_exception0, cdb_exception1  out  1  lane exception
- prf_result0, prf_result1  out  DATA_W  lane result
- prf_write_enable0, prf_write_enable1  out  1  PRF write strobe

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - all lane outputs 0;
  - round-robin pointer rr_ptr = 0.
- fu_grant is combinational. It is forced to 0 during reset and during flush.
- Request/grant handshake:
  - A unit asserts fu_req[i] with its payload and holds both stable until it sees fu_grant[i]=1 at a posedge.
  - The request must drop, or present a new result, the cycle after the grant.
- Selection:
  - Scan indices rr_ptr, rr_ptr+1, …, wrapping modulo NUM_FU.
  - The first requester found takes lane 0; the second takes lane 1.
  - At most 2 grants per cycle.
- Pointer update at posedge:
  - If any grant was issued, rr_ptr <= (index of the last granted requester + 1) mod NUM_FU.
  - Otherwise rr_ptr holds.
  - Wrap from NUM_FU-1 to 0 is required.
- Latency: the grant in cycle t makes the lane outputs valid in cycle t+1, as registered outputs.
- Lane register load:
  - cdb_completeN <= 1 when lane N was granted, else 0. Lanes are never left holding a stale valid.
  - Payload registers load only when the lane is granted. Otherwise they hold their value (don't-care while complete=0).
- prf_write_enableN = cdb_completeN & ~cdb_exceptionN & (cdb_dest_ar_idxN != 31). Register 31 is the zero register.
- Only lane 1 granted is impossible: lane 0 is always filled first.
- With exactly one requester, the result goes to lane 0 and cdb_complete1 = 0.
- Flush:
  - No grants that cycle.
  - Both cdb_complete and both prf_write_enable go to 0 next cycle.
  - rr_ptr holds.
  - Requesters are expected to drop fu_req themselves.
- A flush and a reset asserted together act as reset.
- Reset mid-stream: everything clears next cycle regardless of pending requests.

Optional Feature:
- Macro CDB_ARB_MUL_PRIO_EN.
- When defined:
  - The multiplier (index NUM_FU-1) has absolute priority: if fu_req[NUM_FU-1]=1 it always takes lane 0.
  - The remaining lane is filled by the round-robin scan over the other units.
  - rr_ptr updates only from non-multiplier grants and skips index NUM_FU-1.
  - Rationale: the multiplier pipeline cannot stall.
- When undefined: the multiplier is an ordinary round-robin participant.

Test Plan:
- Reset with fu_req=4'b1111 held: no grants; all lane outputs 0 for the reset cycle and the next; rr_ptr=0 afterwards.
- Single request: fu_req=4'b0001, result 35, ar 3, pr 40 -> grant 4'b0001. Next cycle cdb_complete0=1, prf_result0=35, cdb_prf_dest_pr_idx0=40, prf_write_enable0=1, cdb_complete1=0.
- Four units requesting continuously from rr_ptr=0, default build:
  - grants are 0011, then 1100, then 0011;
  - rr_ptr sequence is 0, 2, 0;
  - each unit is served once every 2 cycles.
- Zero-register destination and exception:
  - ar=31 -> complete=1, write_enable=0;
  - exception=1 with ar=5 -> complete=1, write_enable=0.
- Flush with fu_req=4'b0110 -> grant 0 that cycle; both complete=0 next cycle. With requests unchanged the cycle after the flush -> grant 0110.
- With CDB_ARB_MUL_PRIO_EN, fu_req=4'b1011, rr_ptr=0 -> unit 3 on lane 0, unit 0 on lane 1. Without the macro -> units 0 and 1.
